sd_data_rx_deser: RTL and testbench
===================================

Name: sd_data_rx_deser

Overview:
- Upstream neighbour of the RX FIFO filler, running in the SD card clock domain.
- Samples the SD DAT lines and detects start bits.
- Deserialises each data block into SD_BUS_W-wide nibbles and pushes them as `dat_o`/`wr_o` into the RX FIFO write port.
- Checks per-lane CRC16 and end bits, and counts multi-block transfers.
- Reports busy, done, CRC/framing error, FIFO overflow and start-bit timeout to the data master.

Parameters:
- BUS_W, 4, DAT lane count; equals `SD_BUS_W`; only 4 supported.
- BLKSZ_W, 12, width of the block-size-in-bytes field.
- BLKNUM_W, 8, width of the block-count field.
- TIMEOUT, 65535, maximum number of `clk` cycles to wait for a start bit.

Ports:
- clk, in, 1: SD clock (`sd_clk`); all logic rises on it.
- rst, in, 1: reset, asynchronous, active-low.
- en, in, 1: level; 1 runs a transfer, 0 aborts and holds IDLE.
- blk_size, in, BLKSZ_W: bytes per block; sampled on `en` rising.
- blk_num, in, BLKNUM_W: number of blocks; sampled on `en` rising.
- sd_dat_i, in, BUS_W: DAT lines from the card.
- fifo_full_i, in, 1: RX FIFO full.
- dat_o, out, BUS_W: nibble to the FIFO.
- wr_o, out, 1: FIFO write strobe, one cycle per nibble.
- busy_o, out, 1: transfer in progress.
- done_o, out, 1: one-cycle pulse when the transfer ends (normally or by timeout).
- crc_err_o, out, 1: sticky; CRC mismatch or bad end bit.
- overflow_o, out, 1: sticky; a write was dropped because the FIFO was full.
- timeout_o, out, 1: sticky; no start bit arrived within TIMEOUT cycles.

Behaviour:
- Reset (`rst`=0): state IDLE; all outputs 0; all counters 0.
- IDLE:
  - On the cycle `en` is seen 0→1: latch `blk_size`/`blk_num`, clear the sticky flags, set `busy_o`=1, go to WAIT_START.
  - If the latched `blk_size`==0 or `blk_num`==0: go instead to FINISH (`done_o` pulse, no writes).
- WAIT_START:
  - Timeout counter increments each cycle.
  - `sd_dat_i[0]`==0 → clear the per-lane CRCs, nibble counter = 2*`blk_size`, go to DATA.
  - Counter reaches TIMEOUT-1 without a start bit → set `timeout_o`, go to FINISH.
- DATA:
  - Each cycle: sample `sd_dat_i`, shift `sd_dat_i[k]` into lane k's CRC16 (x^16+x^12+x^5+1, init 0), decrement the nibble counter.
  - Next cycle: `dat_o`=sampled nibble, `wr_o`=1, unless `fifo_full_i` is 1 in the sampling cycle. In that case `wr_o` stays 0 and `overflow_o` sets; CRC still updates.
  - Write latency is 1 cycle; the first nibble is the high nibble of byte 0.
  - Counter reaching 0 → go to CRC.
- CRC:
  - 16 cycles.
  - Lane k compares the received bit with the MSB of its CRC register, then shifts the register left with zero fill.
  - Any mismatch sets `crc_err_o`.
- END (1 cycle):
  - Any lane 0 sets `crc_err_o`.
  - Decrement the block counter.
  - Counter nonzero → WAIT_START with the timeout counter cleared; counter zero → FINISH.
- FINISH (1 cycle): `done_o`=1, `busy_o`→0 on the next cycle, go to IDLE.
- Sticky flags hold until the next `en` rising.
- Abort: `en`=0 in any state except IDLE:
  - Next cycle is IDLE, `busy_o`=0, `wr_o`=0.
  - A nibble sampled in the same cycle is not written.
  - No `done_o` pulse; sticky flags are retained.
- A new `en` rising is accepted only from IDLE; raising `en` while already 1 has no effect.
- Counters:
  - Nibble counter width BLKSZ_W+1.
  - Timeout counter width covers TIMEOUT.
  - No wraparound: counters saturate at their terminal value.

Decomposition:
- Shared package (`sd_defines`):
  - State encoding localparams (IDLE, WAIT_START, DATA, CRC, END, FINISH).
  - CRC16 polynomial constant.
  - `SD_BUS_W`.
- Sub-module `sd_crc16_lane`:
  - Serial CRC16 with `clr`, `en` and bit input plus a 16-bit value output.
  - Instantiated BUS_W times.
  - The compare/shift for the CRC phase lives in the parent.

Test Plan:
1. `blk_size`=4, `blk_num`=1, start after 3 idle cycles, data bytes 0x12,0x34,0x56,0x78, correct CRCs, end bits 1 → 8 `wr_o` pulses with `dat_o` 1,2,3,4,5,6,7,8; `done_o` 1 cycle after the end bit; `crc_err_o`=0.
2. Same as 1 but lane 2 CRC bit 5 flipped → same 8 writes; `crc_err_o`=1; `done_o` pulses; flag cleared on the next `en` rising.
3. TIMEOUT=16, DAT held 0xF → `timeout_o`=1 and `done_o` pulse 16 cycles after WAIT_START entry; zero writes; `busy_o` then 0.
4. Same as 1 with `fifo_full_i`=1 while nibbles 3–4 are sampled → 6 writes (1,2,5,6,7,8); `overflow_o`=1; `crc_err_o`=0.
5. `blk_num`=2, `blk_size`=4, 2-cycle gap between blocks → 16 writes; exactly one `done_o`, after the second end bit.
6. `en` dropped after the 3rd data nibble → IDLE next cycle, no further `wr_o`, no `done_o`. Then assert `rst` low mid-transfer → all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/sd_defines.sv
// Shared definitions for the SD data receive path: bus width, CRC16
// polynomial and the deserialiser state encoding.
package sd_defines;

    localparam int SD_BUS_W = 4;

    // CRC16-CCITT generator x^16 + x^12 + x^5 + 1 (x^16 term implicit)
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_START = 3'd1;
    localparam logic [2:0] ST_DATA       = 3'd2;
    localparam logic [2:0] ST_CRC        = 3'd3;
    localparam logic [2:0] ST_END        = 3'd4;
    localparam logic [2:0] ST_FINISH     = 3'd5;

endpackage

// File: rtl/sd_crc16_lane.sv
// Serial CRC16 for one DAT lane. The caller makes the register shift left
// with zero fill by feeding back its own MSB as the data bit.
module sd_crc16_lane
    import sd_defines::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        data_bit,
    output logic [15:0] value
);

    logic feedback;

    assign feedback = data_bit ^ value[15];

    // LFSR step: clear has priority over shifting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en) begin
            value <= {value[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/sd_data_rx_deser.sv
// SD DAT receive deserialiser: waits for a start bit, pushes each nibble to
// the RX FIFO, checks per-lane CRC16 and end bits, repeats for each block.
//
// Write handshake: wr_o is a one-cycle strobe qualifying dat_o; there is no
// back-pressure on the card, so fifo_full_i high in a sampling cycle drops
// that nibble and latches overflow_o instead of stalling.
module sd_data_rx_deser
    import sd_defines::*;
#(
    parameter int BUS_W    = SD_BUS_W,
    parameter int BLKSZ_W  = 12,
    parameter int BLKNUM_W = 8,
    parameter int TIMEOUT  = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [BLKSZ_W-1:0]  blk_size,
    input  logic [BLKNUM_W-1:0] blk_num,
    input  logic [BUS_W-1:0]    sd_dat_i,
    input  logic                fifo_full_i,
    output logic [BUS_W-1:0]    dat_o,
    output logic                wr_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                crc_err_o,
    output logic                overflow_o,
    output logic                timeout_o,
    output logic [2:0]          state_o
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]     TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]     TO_ONE   = TO_W'(1);
    localparam logic [BLKSZ_W:0]    NCNT_ONE = (BLKSZ_W + 1)'(1);
    localparam logic [BLKNUM_W-1:0] BCNT_ONE = BLKNUM_W'(1);

    logic [2:0]          state;
    logic                en_q;
    logic                rise;
    logic [BLKSZ_W-1:0]  size_q;
    logic [BLKNUM_W-1:0] bcnt;
    logic [BLKSZ_W:0]    ncnt;
    logic [TO_W-1:0]     tcnt;
    logic [3:0]          ccnt;

    logic                crc_clr;
    logic                crc_en;
    logic [BUS_W-1:0]    lane_bit;
    logic [BUS_W-1:0]    lane_msb;
    logic                crc_miss;
    logic [15:0]         lane_crc [BUS_W];

    assign rise     = en & ~en_q;
    assign crc_clr  = en && (state == ST_WAIT_START) && !sd_dat_i[0];
    assign crc_en   = en && ((state == ST_DATA) || (state == ST_CRC));
    assign crc_miss = |(sd_dat_i ^ lane_msb);

    assign busy_o  = (state != ST_IDLE);
    assign done_o  = (state == ST_FINISH);
    assign state_o = state;

    // During the CRC phase each lane feeds back its own MSB, which makes the
    // LFSR a plain left shift so the MSB walks out the expected CRC bits.
    genvar k;
    generate
        for (k = 0; k < BUS_W; k++) begin : g_lane
            logic unused_low_bits;
            assign lane_bit[k]     = (state == ST_CRC) ? lane_crc[k][15] : sd_dat_i[k];
            assign lane_msb[k]     = lane_crc[k][15];
            assign unused_low_bits = ^lane_crc[k][14:0];

            sd_crc16_lane u_crc (
                .clk      (clk),
                .rst      (rst),
                .clr      (crc_clr),
                .en       (crc_en),
                .data_bit (lane_bit[k]),
                .value    (lane_crc[k])
            );
        end
    endgenerate

    // Transfer FSM with counters, FIFO write strobe and sticky status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            en_q       <= 1'b0;
            size_q     <= '0;
            bcnt       <= '0;
            ncnt       <= '0;
            tcnt       <= '0;
            ccnt       <= '0;
            dat_o      <= '0;
            wr_o       <= 1'b0;
            crc_err_o  <= 1'b0;
            overflow_o <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            en_q <= en;
            wr_o <= 1'b0;
            if (state != ST_IDLE && !en) begin
                // abort: drop whatever was sampled, keep sticky flags
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            size_q     <= blk_size;
                            bcnt       <= blk_num;
                            tcnt       <= '0;
                            crc_err_o  <= 1'b0;
                            overflow_o <= 1'b0;
                            timeout_o  <= 1'b0;
                            state      <= (blk_size == '0 || blk_num == '0) ? ST_FINISH : ST_WAIT_START;
                        end
                    end
                    ST_WAIT_START: begin
                        if (!sd_dat_i[0]) begin
                            ncnt  <= {size_q, 1'b0};
                            state <= ST_DATA;
                        end else if (tcnt == TO_LAST) begin
                            timeout_o <= 1'b1;
                            state     <= ST_FINISH;
                        end else begin
                            tcnt <= tcnt + TO_ONE;
                        end
                    end
                    ST_DATA: begin
                        if (fifo_full_i) begin
                            overflow_o <= 1'b1;
                        end else begin
                            wr_o  <= 1'b1;
                            dat_o <= sd_dat_i;
                        end
                        if (ncnt != '0) begin
                            ncnt <= ncnt - NCNT_ONE;
                        end
                        if (ncnt <= NCNT_ONE) begin
                            ccnt  <= 4'd0;
                            state <= ST_CRC;
                        end
                    end
                    ST_CRC: begin
                        if (crc_miss) begin
                            crc_err_o <= 1'b1;
                        end
                        if (ccnt == 4'd15) begin
                            state <= ST_END;
                        end else begin
                            ccnt <= ccnt + 4'd1;
                        end
                    end
                    ST_END: begin
                        if (sd_dat_i != '1) begin
                            crc_err_o <= 1'b1;
                        end
                        if (bcnt != '0) begin
                            bcnt <= bcnt - BCNT_ONE;
                        end
                        if (bcnt <= BCNT_ONE) begin
                            state <= ST_FINISH;
                        end else begin
                            tcnt  <= '0;
                            state <= ST_WAIT_START;
                        end
                    end
                    ST_FINISH: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_data_rx_deser.sv
// Bench for sd_data_rx_deser: card-side driver tasks, a write-port monitor
// against an expected-nibble queue, and CRCs from polynomial long division.
module tb_sd_data_rx_deser;
    import sd_defines::*;

    localparam int TIMEOUT = 16;
    localparam int MAX_NIB = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [11:0] blk_size;
    logic [7:0]  blk_num;
    logic [3:0]  sd_dat_i;
    logic        fifo_full_i;
    logic [3:0]  dat_o;
    logic        wr_o;
    logic        busy_o;
    logic        done_o;
    logic        crc_err_o;
    logic        overflow_o;
    logic        timeout_o;
    logic [2:0]  state_o;

    int          n_vec = 0;
    int          n_err = 0;
    int          done_seen = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_exp;
    logic [7:0]  data_buf[$];
    bit          full_buf[$];
    bit          lane_bits[4][MAX_NIB];

    sd_data_rx_deser #(
        .BUS_W(4), .BLKSZ_W(12), .BLKNUM_W(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .blk_size(blk_size), .blk_num(blk_num),
        .sd_dat_i(sd_dat_i), .fifo_full_i(fifo_full_i), .dat_o(dat_o), .wr_o(wr_o),
        .busy_o(busy_o), .done_o(done_o), .crc_err_o(crc_err_o),
        .overflow_o(overflow_o), .timeout_o(timeout_o), .state_o(state_o)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // monitor: every write strobe pops one expected nibble
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (done_o === 1'b1) done_seen++;
            if (wr_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL wr_unexpected: got write of %0h, expected no write (t=%0t)", dat_o, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("wr_data", 32'(dat_o), 32'(mon_exp));
                end
            end
        end
    end

    // CRC16 of lane k's first n bits: remainder of M(x)*x^16 divided by G(x)
    function automatic logic [15:0] poly_crc(input int k, input int n);
        bit          m[MAX_NIB + 16];
        logic [16:0] g;
        logic [15:0] r;
        g = 17'h11021;
        for (int i = 0; i < MAX_NIB + 16; i++) m[i] = 1'b0;
        for (int i = 0; i < n; i++) m[i] = lane_bits[k][i];
        for (int i = 0; i < n; i++)
            if (m[i]) for (int j = 0; j < 17; j++) m[i + j] = m[i + j] ^ g[16 - j];
        for (int j = 0; j < 16; j++) r[15 - j] = m[n + j];
        return r;
    endfunction

    // one card clock: present DAT and FIFO-full, then step past the edge
    task automatic cyc(input logic [3:0] d, input logic f);
        sd_dat_i    = d;
        fifo_full_i = f;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int nbytes, input bit rand_full);
        data_buf.delete();
        full_buf.delete();
        for (int i = 0; i < nbytes; i++) data_buf.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 2 * nbytes; i++) full_buf.push_back(rand_full && ($urandom_range(0, 4) == 0));
    endtask

    // full transfer driven from data_buf/full_buf; lane/bit < 0 means no fault
    task automatic do_transfer(input int size, input int num, input int pre_idle, input int gap,
                               input int flip_lane, input int flip_bit, input int bad_end_lane);
        bit          exp_crc;
        bit          exp_ovf;
        int          d0;
        int          base;
        logic [3:0]  d;
        logic [15:0] crc[4];
        exp_crc  = 1'b0;
        exp_ovf  = 1'b0;
        base     = 0;
        blk_size = size[11:0];
        blk_num  = num[7:0];
        d0       = done_seen;
        en       = 1'b1;
        cyc(4'hF, 1'b0);
        check("busy_start", 32'(busy_o), 32'd1);
        check("crc_err_cleared", 32'(crc_err_o), 32'd0);
        check("overflow_cleared", 32'(overflow_o), 32'd0);
        check("timeout_cleared", 32'(timeout_o), 32'd0);
        for (int b = 0; b < num; b++) begin
            for (int i = 0; i < ((b == 0) ? pre_idle : gap); i++) cyc(4'hF, 1'b0);
            cyc(4'h0, 1'b0);
            for (int n = 0; n < 2 * size; n++) begin
                logic [7:0] by;
                logic [3:0] nib;
                by  = data_buf[b * size + n / 2];
                nib = (n % 2 == 0) ? by[7:4] : by[3:0];
                for (int k = 0; k < 4; k++) lane_bits[k][n] = nib[k];
                if (full_buf[base + n]) exp_ovf = 1'b1;
                else exp_q.push_back(nib);
                cyc(nib, full_buf[base + n]);
            end
            for (int k = 0; k < 4; k++) crc[k] = poly_crc(k, 2 * size);
            for (int j = 15; j >= 0; j--) begin
                for (int k = 0; k < 4; k++) d[k] = crc[k][j];
                if (b == 0 && flip_lane >= 0 && j == flip_bit) begin
                    d[flip_lane[1:0]] = ~d[flip_lane[1:0]];
                    exp_crc = 1'b1;
                end
                cyc(d, 1'b0);
            end
            d = 4'hF;
            if (b == num - 1 && bad_end_lane >= 0) begin
                d[bad_end_lane[1:0]] = 1'b0;
                exp_crc = 1'b1;
            end
            cyc(d, 1'b0);
            base += 2 * size;
            if (b < num - 1) check("no_done_between_blocks", 32'(done_o), 32'd0);
            else check("done_after_end_bit", 32'(done_o), 32'd1);
        end
        check("crc_err", 32'(crc_err_o), 32'(exp_crc));
        check("overflow", 32'(overflow_o), 32'(exp_ovf));
        check("timeout_clear", 32'(timeout_o), 32'd0);
        en = 1'b0;
        cyc(4'hF, 1'b0);
        check("busy_after_done", 32'(busy_o), 32'd0);
        check("done_count", 32'(done_seen - d0), 32'd1);
        check("crc_err_sticky", 32'(crc_err_o), 32'(exp_crc));
        check("writes_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_timeout();
        int d0;
        blk_size = 12'd4;
        blk_num  = 8'd1;
        d0       = done_seen;
        en       = 1'b1;
        cyc(4'hF, 1'b0);
        check("to_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(4'hF, 1'b0);
        check("to_no_done_early", 32'(done_o), 32'd0);
        check("to_flag_early", 32'(timeout_o), 32'd0);
        cyc(4'hF, 1'b0);
        check("to_done", 32'(done_o), 32'd1);
        check("to_flag", 32'(timeout_o), 32'd1);
        cyc(4'hF, 1'b0);
        check("to_busy_low", 32'(busy_o), 32'd0);
        check("to_flag_sticky", 32'(timeout_o), 32'd1);
        check("to_done_count", 32'(done_seen - d0), 32'd1);
        en = 1'b0;
        cyc(4'hF, 1'b0);
    endtask

    task automatic do_zero_size();
        int d0;
        blk_size = 12'd0;
        blk_num  = 8'd3;
        d0       = done_seen;
        en       = 1'b1;
        cyc(4'h0, 1'b0);
        check("zero_done", 32'(done_o), 32'd1);
        cyc(4'h0, 1'b0);
        check("zero_busy_low", 32'(busy_o), 32'd0);
        check("zero_done_count", 32'(done_seen - d0), 32'd1);
        en = 1'b0;
        cyc(4'hF, 1'b0);
    endtask

    task automatic do_abort_and_reset();
        int         d0;
        logic [3:0] nib;
        blk_size = 12'd4;
        blk_num  = 8'd1;
        d0       = done_seen;
        en       = 1'b1;
        cyc(4'hF, 1'b0);
        cyc(4'h0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            nib = 4'($urandom_range(0, 15));
            exp_q.push_back(nib);
            cyc(nib, 1'b0);
        end
        en = 1'b0;
        cyc(4'($urandom_range(0, 15)), 1'b0);
        check("abort_idle", 32'(state_o), 32'(ST_IDLE));
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_no_wr", 32'(wr_o), 32'd0);
        for (int i = 0; i < 4; i++) cyc(4'($urandom_range(0, 15)), 1'b0);
        check("abort_no_done", 32'(done_seen - d0), 32'd0);
        check("abort_drained", 32'(exp_q.size()), 32'd0);
        // restart, then hit reset mid-data between clock edges
        en = 1'b1;
        cyc(4'hF, 1'b1);
        cyc(4'h0, 1'b0);
        exp_q.push_back(4'hA);
        cyc(4'hA, 1'b0);
        exp_q.push_back(4'h5);
        cyc(4'h5, 1'b1);
        exp_q.push_back(4'h9);
        cyc(4'h9, 1'b0);
        check("pre_reset_overflow", 32'(overflow_o), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_wr", 32'(wr_o), 32'd0);
        check("rst_async_dat", 32'(dat_o), 32'd0);
        check("rst_async_busy", 32'(busy_o), 32'd0);
        check("rst_async_overflow", 32'(overflow_o), 32'd0);
        check("rst_async_state", 32'(state_o), 32'(ST_IDLE));
        exp_q.delete();
        en = 1'b0;
        cyc(4'hF, 1'b0);
        rst = 1'b1;
        cyc(4'hF, 1'b0);
    endtask

    // main sequence
    initial begin
        rst         = 1'b0;
        en          = 1'b0;
        blk_size    = '0;
        blk_num     = '0;
        sd_dat_i    = 4'hF;
        fifo_full_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_wr", 32'(wr_o), 32'd0);
        check("reset_dat", 32'(dat_o), 32'd0);
        check("reset_flags", 32'({crc_err_o, overflow_o, timeout_o}), 32'd0);
        check("reset_state", 32'(state_o), 32'(ST_IDLE));
        rst = 1'b1;
        cyc(4'hF, 1'b0);
        cyc(4'hF, 1'b0);

        // single block, good CRC, then with lane 2 CRC bit 5 corrupted
        fill(4, 1'b0);
        data_buf = '{8'h12, 8'h34, 8'h56, 8'h78};
        do_transfer(4, 1, 3, 0, -1, 0, -1);
        do_transfer(4, 1, 3, 0, 2, 5, -1);

        // nibbles 3 and 4 dropped by a full FIFO
        full_buf[2] = 1'b1;
        full_buf[3] = 1'b1;
        do_transfer(4, 1, 3, 0, -1, 0, -1);

        do_timeout();

        // two blocks with a 2-cycle gap
        fill(8, 1'b0);
        do_transfer(4, 2, 1, 2, -1, 0, -1);

        do_zero_size();

        // randomized transfers
        for (int it = 0; it < 10; it++) begin
            int size;
            int num;
            int fl;
            int fb;
            int be;
            size = $urandom_range(1, 8);
            num  = $urandom_range(1, 3);
            fill(size * num, 1'b1);
            fl = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : -1;
            fb = $urandom_range(0, 15);
            be = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            do_transfer(size, num, $urandom_range(0, 10), $urandom_range(0, 10), fl, fb, be);
        end

        do_abort_and_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
